// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the read-modify-write data memory.
// Holds the access-code encoding, the FSM states and the byte-lane functions.
package mem_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_LBU = 3'b011,
      OP_LHU = 3'b100,
      OP_SB  = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } mem_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MERGE,
      S_WR,
      S_RESP
   } state_e;

   function automatic logic is_store(input mem_op_e op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic is_misaligned(input mem_op_e op,
                                          input logic [1:0] off);
      logic m;
      m = 1'b0;
      unique case (op)
         OP_LH, OP_LHU, OP_SH: m = off[0];
         OP_LW, OP_SW:         m = (off != 2'b00);
         default:              m = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] load_shift(input logic [31:0] word,
                                              input logic [1:0] off);
      return word >> {off, 3'b000};
   endfunction

   // Replace only the addressed lane; other lanes keep the read word.
   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input mem_op_e op,
                                              input logic [1:0] off);
      logic [31:0] r;
      r = word;
      if (op == OP_SB)
         r[{off, 3'b000} +: 8] = wdata[7:0];
      else if (op == OP_SH)
         r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      return r;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide 1R1W synchronous RAM with one-cycle read latency.
// Contents are never reset; read data holds until the next read.
module dmem_array #(
   parameter int SIZE = 12
) (
   input  logic            clk,
   input  logic            re,
   input  logic [SIZE-3:0] raddr,
   output logic [31:0]     rdata,
   input  logic            we,
   input  logic [SIZE-3:0] waddr,
   input  logic [31:0]     wdata
);

   localparam int DEPTH = 2 ** (SIZE - 2);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/data_mem_rmw.sv
// Data memory front end: aligned loads, word stores and byte/halfword
// stores done as read-modify-write, behind a valid/ready request/response.
module data_mem_rmw
   import mem_pkg::*;
#(
   parameter int SIZE = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      memCtrl,
   input  logic [SIZE-1:0] addrIn,
   input  logic [31:0]     dataWI,
   input  logic            reqValid,
   output logic            reqReady,
   output logic            rspValid,
   input  logic            rspReady,
   output logic [31:0]     dataRO,
   output logic            misalign
);

   state_e          state;
   mem_op_e         op_q;
   mem_op_e         op_in;
   logic [SIZE-1:0] addr_q;
   logic [31:0]     wdata_q;

   logic            ram_re;
   logic            ram_we;
   logic [31:0]     ram_rdata;
   logic [31:0]     ram_wdata;

   assign op_in = mem_op_e'(memCtrl);

   // The read is launched on the accept edge so data is ready in RD.
   assign ram_re = (state == S_IDLE) && reqValid;
   assign ram_we = (state == S_WR) || (state == S_MERGE);

   assign ram_wdata = (state == S_WR) ? wdata_q
                    : merge_lane(ram_rdata, wdata_q, op_q, addr_q[1:0]);

   dmem_array #(
      .SIZE (SIZE)
   ) u_array (
      .clk   (clk),
      .re    (ram_re),
      .raddr (addrIn[SIZE-1:2]),
      .rdata (ram_rdata),
      .we    (ram_we),
      .waddr (addr_q[SIZE-1:2]),
      .wdata (ram_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         reqReady <= 1'b1;
         rspValid <= 1'b0;
         dataRO   <= '0;
         misalign <= 1'b0;
         op_q     <= OP_LB;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (reqValid) begin
                  op_q     <= op_in;
                  addr_q   <= addrIn;
                  wdata_q  <= dataWI;
                  reqReady <= 1'b0;
                  if (is_misaligned(op_in, addrIn[1:0])) begin
                     state    <= S_RESP;
                     rspValid <= 1'b1;
                     misalign <= 1'b1;
                     dataRO   <= '0;
                  end else if (op_in == OP_SW) begin
                     state <= S_WR;
                  end else begin
                     state <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (is_store(op_q)) begin
                  state <= S_MERGE;
               end else begin
                  state    <= S_RESP;
                  rspValid <= 1'b1;
                  misalign <= 1'b0;
                  dataRO   <= load_shift(ram_rdata, addr_q[1:0]);
               end
            end
            S_MERGE, S_WR: begin
               state    <= S_RESP;
               rspValid <= 1'b1;
               misalign <= 1'b0;
               dataRO   <= '0;
            end
            S_RESP: begin
               if (rspReady) begin
                  state    <= S_IDLE;
                  reqReady <= 1'b1;
                  rspValid <= 1'b0;
                  misalign <= 1'b0;
                  dataRO   <= '0;
               end
            end
            default: begin
               state    <= S_IDLE;
               reqReady <= 1'b1;
               rspValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/data_mem_rmw.md
DATA_MEM_RMW -- requirements
Module: data_mem_rmw

Interface
REQ-001 The block SHALL have parameter SIZE, default 12, giving the byte-address width; the storage depth is 2^(SIZE-2) 32-bit words.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port memCtrl, input, 3, the access code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-005 The block SHALL have port addrIn, input, SIZE, the byte address.
REQ-006 The block SHALL have port dataWI, input, 32, store data, zero-extended with the payload in the low byte or halfword.
REQ-007 The block SHALL have port reqValid, input, 1, request present; port reqReady, output, 1, request accepted.
REQ-008 The block SHALL have port rspValid, output, 1, response present; port rspReady, input, 1, response consumed.
REQ-009 The block SHALL have port dataRO, output, 32, the raw load word, right-aligned so the addressed byte or halfword is in bits [7:0] or [15:0] (feeds the width/sign stage).
REQ-010 The block SHALL have port misalign, output, 1, valid with rspValid: the request was misaligned.

Function
REQ-011 The FSM SHALL have states IDLE, RD, MERGE, WR and RESP; reqReady SHALL be 1 only in IDLE.
REQ-012 A request SHALL be accepted on a rising edge with reqValid=1 in IDLE; memCtrl, addrIn and dataWI SHALL be latched on that edge.
REQ-013 Misalignment SHALL be defined as LH/LHU/SH with addrIn[0]=1, or LW/SW with addrIn[1:0]!=0; a misaligned request SHALL go IDLE->RESP with misalign=1 and dataRO=0, and SHALL NOT write storage.
REQ-014 Loads SHALL follow IDLE->RD->RESP; dataRO SHALL equal the stored word shifted right by 8*addr[1:0] bits; rspValid SHALL rise 2 cycles after acceptance.
REQ-015 SW SHALL follow IDLE->WR->RESP and write dataWI to word addr[SIZE-1:2] in the WR cycle.
REQ-016 SB/SH SHALL follow IDLE->RD->MERGE->RESP; MERGE SHALL write the read word with only the addressed byte lane (SB) or halfword lane (SH) replaced by dataWI[7:0] or dataWI[15:0]; the other lanes SHALL be unchanged.
REQ-017 Store responses SHALL drive dataRO=0 and misalign=0.
REQ-018 RESP SHALL hold rspValid, dataRO and misalign stable until rspReady=1, then return to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-019 Undefined memCtrl values SHALL NOT arise, because all 8 codes are defined; addresses SHALL wrap modulo 2^SIZE.
REQ-020 The storage array SHALL have 1-cycle synchronous read latency; a read issued in the cycle after a write to the same word SHALL return the new data.

Reset
REQ-021 On rst_n=0 the FSM SHALL go to IDLE asynchronously, with reqReady=1 after release and rspValid=0, dataRO=0, misalign=0.
REQ-022 Reset asserted before the WR or MERGE write edge SHALL suppress that write; storage contents SHALL NOT be reset.

Structure
REQ-023 Package mem_pkg SHALL hold the memCtrl encoding enum, the FSM state enum and the lane-merge/shift functions.
REQ-024 Storage SHALL be a sub-module dmem_array (1R1W synchronous word RAM, parameter SIZE).

Verification
REQ-025 SW 0xDEADBEEF @0x010, then LW @0x010 -> dataRO=0xDEADBEEF, misalign=0, rspValid 2 cycles after acceptance.
REQ-026 After REQ-025, SB dataWI=0x000000AA @0x012, then LW @0x010 -> 0xDEAABEEF; LB @0x012 -> dataRO[7:0]=0xAA.
REQ-027 SH 0x00001234 @0x011 -> misalign=1, no write; LW @0x010 still 0xDEAABEEF.
REQ-028 Hold rspReady=0 for 5 cycles -> rspValid and dataRO stable, reqReady=0; release -> IDLE the next cycle.
REQ-029 Assert rst_n=0 during MERGE of SH 0xBEEF @0x014 -> no write; rspValid=0; LW @0x014 returns the prior value.
REQ-030 Back-to-back SW 0x11111111 @0x020 then LW @0x020 -> 0x11111111 (write-then-read ordering).
